// File: rtl/store_write_buffer_if.sv
// Store-path bundle between MEM stage, load hazard check and data bus.
interface store_write_buffer_if;
  logic        st_valid;
  logic [7:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        flush;
  logic        st_ready;
  logic        stall_o;
  logic        st_ade_o;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard_o;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        buf_empty;

  modport slave (
    input  st_valid, st_op, st_addr, st_data, flush, ld_valid, ld_addr, mem_ack,
    output st_ready, stall_o, st_ade_o, ld_hazard_o, mem_req, mem_addr, mem_wstrb,
           mem_wdata, buf_empty
  );

  modport master (
    output st_valid, st_op, st_addr, st_data, flush, ld_valid, ld_addr, mem_ack,
    input  st_ready, stall_o, st_ade_o, ld_hazard_o, mem_req, mem_addr, mem_wstrb,
           mem_wdata, buf_empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: lane-aligns MEM-stage stores, queues them in a FIFO and
// drains them in order over a req/ack data-bus handshake.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  store_write_buffer_if.slave sbif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;

  logic [29:0]      e_addr  [DEPTH];
  logic [3:0]       e_strb  [DEPTH];
  logic [31:0]      e_wdata [DEPTH];
  logic [DEPTH-1:0] e_vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [1:0]  lane;
  logic [31:0] r;
  logic        is_store;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        hit;
  logic [1:0]  unused_ld_lane;

  assign lane           = sbif.st_addr[1:0];
  assign r              = sbif.st_data;
  assign unused_ld_lane = sbif.ld_addr[1:0];

  // Byte-lane strobes and replicated/shifted data for each store flavour
  always_comb begin
    is_store  = 1'b0;
    lane_strb = 4'b0000;
    lane_data = 32'h0;
    case (sbif.st_op)
      EXE_SB_OP: begin
        is_store  = 1'b1;
        lane_strb = 4'b0001 << lane;
        lane_data = {4{r[7:0]}};
      end
      EXE_SH_OP: begin
        is_store  = 1'b1;
        lane_strb = lane[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{r[15:0]}};
      end
      EXE_SW_OP: begin
        is_store  = 1'b1;
        lane_strb = 4'b1111;
        lane_data = r;
      end
      EXE_SWL_OP: begin
        is_store = 1'b1;
        case (lane)
          2'b00:   begin lane_strb = 4'b0001; lane_data = {24'h0, r[31:24]}; end
          2'b01:   begin lane_strb = 4'b0011; lane_data = {16'h0, r[31:16]}; end
          2'b10:   begin lane_strb = 4'b0111; lane_data = {8'h0, r[31:8]};   end
          default: begin lane_strb = 4'b1111; lane_data = r;                 end
        endcase
      end
      EXE_SWR_OP: begin
        is_store = 1'b1;
        case (lane)
          2'b00:   begin lane_strb = 4'b1111; lane_data = r;                 end
          2'b01:   begin lane_strb = 4'b1110; lane_data = {r[23:0], 8'h0};   end
          2'b10:   begin lane_strb = 4'b1100; lane_data = {r[15:0], 16'h0};  end
          default: begin lane_strb = 4'b1000; lane_data = {r[7:0], 24'h0};   end
        endcase
      end
      default: ;
    endcase
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign sbif.st_ready = ~rst & ~full;
  assign sbif.stall_o  = sbif.st_valid & ~sbif.st_ready & ~sbif.flush;
  assign sbif.st_ade_o = sbif.st_valid &
                         (((sbif.st_op == EXE_SH_OP) & lane[0]) |
                          ((sbif.st_op == EXE_SW_OP) & (lane != 2'b00)));

  assign push = sbif.st_valid & sbif.st_ready & ~sbif.flush & ~sbif.st_ade_o & is_store;
  assign pop  = ~empty & sbif.mem_ack;

  // Loads must wait while any queued store targets the same word
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_vld[i] && (e_addr[i] == sbif.ld_addr[31:2])) hit = 1'b1;
    end
  end
  assign sbif.ld_hazard_o = sbif.ld_valid & hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_vld  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        e_addr[wr_ptr]  <= sbif.st_addr[31:2];
        e_strb[wr_ptr]  <= lane_strb;
        e_wdata[wr_ptr] <= lane_data;
        e_vld[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        e_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign sbif.buf_empty = empty;
  assign sbif.mem_req   = ~empty;
  assign sbif.mem_addr  = empty ? 32'h0 : {e_addr[rd_ptr], 2'b00};
  assign sbif.mem_wstrb = empty ? 4'h0  : e_strb[rd_ptr];
  assign sbif.mem_wdata = empty ? 32'h0 : e_wdata[rd_ptr];
endmodule
